// File: rtl/nano_pkg.sv
// Shared types for the nanoprocessor: opcodes, control states and the set of
// opcodes whose result updates the carry flag.
package nano_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
    OP_ROL = 4'h8, OP_ROR = 4'h9, OP_LDA = 4'hA, OP_STA = 4'hB,
    OP_JMP = 4'hC, OP_JC  = 4'hD, OP_JZ  = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_AF   = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  // Bit n set: opcode n commits ALU carry-out (arithmetic and rotates).
  localparam logic [15:0] CARRY_OPS_MASK = 16'h030F;

  function automatic logic updates_carry(input opcode_t op);
    return CARRY_OPS_MASK[op];
  endfunction

endpackage

// File: rtl/nano_ctrl.sv
// Nanoprocessor control unit: fetch/execute FSM, PC, IR, AR, ACC and flags.
// Optional single-step gating of instruction fetch with macro NANO_STEP_EN.
//
// state  | meaning
// S_IF   | drive PC to RAM, fetch opcode byte (gated by step when enabled)
// S_AF   | latch opcode, drive PC to RAM for operand/target byte
// S_EX   | latch AR; operand fetch, store, jump or halt
// S_WB   | commit ALU result into ACC and flags
// S_HALT | idle until reset
module nano_ctrl
  import nano_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef NANO_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_rdata,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic [3:0] alu_i,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_s,
  input  logic       alu_cout,
  input  logic       alu_z,
  output logic       halted
);

  state_t     r_state, w_state_nxt;
  opcode_t    r_ir, w_ir_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic [7:0] r_ar, w_ar_nxt;
  logic       r_c, w_c_nxt;
  logic       r_z, w_z_nxt;
  logic       w_go;

`ifdef NANO_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif

  assign ram_wdata = r_acc;
  assign alu_i     = r_ir;
  assign alu_a     = r_acc;
  assign alu_b     = ram_rdata;
  assign alu_cin   = r_c;
  assign halted    = (r_state == S_HALT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IF;
      r_pc    <= RESET_PC;
      r_acc   <= 8'h00;
      r_ir    <= OP_ADD;
      r_ar    <= 8'h00;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_acc   <= w_acc_nxt;
      r_ir    <= w_ir_nxt;
      r_ar    <= w_ar_nxt;
      r_c     <= w_c_nxt;
      r_z     <= w_z_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_nxt    = r_ir;
    w_ar_nxt    = r_ar;
    w_c_nxt     = r_c;
    w_z_nxt     = r_z;
    ram_addr    = r_pc;
    ram_we      = 1'b0;
    case (r_state)
      S_IF: begin
        if (w_go) begin
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = S_AF;
        end
      end
      S_AF: begin
        w_ir_nxt    = opcode_t'(ram_rdata[3:0]);
        w_pc_nxt    = r_pc + 8'd1;
        w_state_nxt = S_EX;
      end
      S_EX: begin
        w_ar_nxt    = ram_rdata;
        w_state_nxt = S_IF;
        case (r_ir)
          OP_STA: begin
            ram_addr = ram_rdata;
            ram_we   = 1'b1;
          end
          OP_JMP: w_pc_nxt = ram_rdata;
          OP_JC:  if (r_c) w_pc_nxt = ram_rdata;
          OP_JZ:  if (r_z) w_pc_nxt = ram_rdata;
          OP_HLT: w_state_nxt = S_HALT;
          default: begin
            ram_addr    = ram_rdata;
            w_state_nxt = S_WB;
          end
        endcase
      end
      S_WB: begin
        w_acc_nxt = alu_s;
        w_z_nxt   = alu_z;
        if (updates_carry(r_ir)) w_c_nxt = alu_cout;
        w_state_nxt = S_IF;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IF;
    endcase
  end

endmodule
